// File: rtl/dpsram_pkg.sv
// Shared constants, slice-count helper and clear-FSM state type for the
// parametrised dual-port SRAM.
package dpsram_pkg;

    localparam int DEF_DW = 64;
    localparam int DEF_AW = 12;
    localparam int DEF_SW = 32;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_READY
    } clr_state_t;

    function automatic int calc_ns(input int dw, input int sw);
        return dw / sw;
    endfunction

endpackage

// File: rtl/dpsram_slice.sv
// One SW-bit slice of the dual-port array: one write enable per port and a
// registered read that holds its value between reads.
module dpsram_slice #(
    parameter int SW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_a,
    input  logic          rd_a,
    input  logic [AW-1:0] addr_a,
    input  logic [SW-1:0] din_a,
    output logic [SW-1:0] q_a,
    input  logic          we_b,
    input  logic          rd_b,
    input  logic [AW-1:0] addr_b,
    input  logic [SW-1:0] din_b,
    output logic [SW-1:0] q_b
);

    logic [SW-1:0] mem [2**AW];

    // The top already masks B off any slice A writes at the same address.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= din_b;
        if (we_a) mem[addr_a] <= din_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (rd_a) q_a <= mem[addr_a];
            if (rd_b) q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/dpsram_param_pipe.sv
// Parametrised true dual-port SRAM with slice enables, A-priority collision
// handling, read-during-write forwarding and optional output register.
// Define DPSRAM_INIT_CLEAR_EN to zero the array after every reset release.
module dpsram_param_pipe
    import dpsram_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int SW   = DEF_SW,
    parameter int OREG = 1,
    localparam int NS  = calc_ns(DW, SW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [NS-1:0] wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] douta,
    output logic          rvalida,
    input  logic          enb,
    input  logic [NS-1:0] web,
    input  logic [AW-1:0] addrb,
    input  logic [DW-1:0] dinb,
    output logic [DW-1:0] doutb,
    output logic          rvalidb,
    output logic          coll,
    output logic          busy
);

    logic          acc_a, acc_b, rd_a, rd_b, same_addr, coll_next;
    logic [NS-1:0] wa_user, wb_user, wa_m, wb_m;
    logic [AW-1:0] addra_i;
    logic [DW-1:0] dina_i;
    logic [NS-1:0] fwd_a, fwd_b;
    logic [DW-1:0] fwd_din_a, fwd_din_b;
    logic          rv1_a, rv1_b;
    logic [DW-1:0] q_a, q_b, d1_a, d1_b;

    assign acc_a   = ena & ~busy;
    assign acc_b   = enb & ~busy;
    assign rd_a    = acc_a & ~|wea;
    assign rd_b    = acc_b & ~|web;
    assign wa_user = acc_a ? wea : '0;
    assign wb_user = acc_b ? web : '0;

`ifdef DPSRAM_INIT_CLEAR_EN
    clr_state_t    state, state_next;
    logic [AW-1:0] clr_cnt;
    logic          clearing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLR_IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLR_CLEAR) clr_cnt <= clr_cnt + AW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLR_IDLE:  state_next = CLR_CLEAR;
            CLR_CLEAR: if (clr_cnt == '1) state_next = CLR_READY;
            default:   state_next = state;
        endcase
    end

    // The sweep borrows port A; user traffic is already blocked by busy.
    assign busy     = (state != CLR_READY);
    assign clearing = (state == CLR_CLEAR);
    assign wa_m     = clearing ? '1 : wa_user;
    assign addra_i  = clearing ? clr_cnt : addra;
    assign dina_i   = clearing ? '0 : dina;
`else
    assign busy    = 1'b0;
    assign wa_m    = wa_user;
    assign addra_i = addra;
    assign dina_i  = dina;
`endif

    assign same_addr = (addra_i == addrb);
    assign wb_m      = wb_user & ~(same_addr ? wa_m : '0);
    assign coll_next = same_addr & |(wa_m & wb_user);

    // Slice masks captured at the read edge pick forwarded data over the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll      <= 1'b0;
            rv1_a     <= 1'b0;
            rv1_b     <= 1'b0;
            fwd_a     <= '0;
            fwd_b     <= '0;
            fwd_din_a <= '0;
            fwd_din_b <= '0;
        end else begin
            coll  <= coll_next;
            rv1_a <= rd_a;
            rv1_b <= rd_b;
            if (rd_a) begin
                fwd_a     <= same_addr ? wb_m : '0;
                fwd_din_a <= dinb;
            end
            if (rd_b) begin
                fwd_b     <= same_addr ? wa_m : '0;
                fwd_din_b <= dina_i;
            end
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_slice
        dpsram_slice #(.SW(SW), .AW(AW)) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .we_a   (wa_m[s]),
            .rd_a   (rd_a),
            .addr_a (addra_i),
            .din_a  (dina_i[s*SW +: SW]),
            .q_a    (q_a[s*SW +: SW]),
            .we_b   (wb_m[s]),
            .rd_b   (rd_b),
            .addr_b (addrb),
            .din_b  (dinb[s*SW +: SW]),
            .q_b    (q_b[s*SW +: SW])
        );
    end

    always_comb begin
        d1_a = q_a;
        d1_b = q_b;
        for (int s = 0; s < NS; s++) begin
            if (fwd_a[s]) d1_a[s*SW +: SW] = fwd_din_a[s*SW +: SW];
            if (fwd_b[s]) d1_b[s*SW +: SW] = fwd_din_b[s*SW +: SW];
        end
    end

    if (OREG != 0) begin : g_oreg
        logic [DW-1:0] douta_r, doutb_r;
        logic          rva_r, rvb_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                douta_r <= '0;
                doutb_r <= '0;
                rva_r   <= 1'b0;
                rvb_r   <= 1'b0;
            end else begin
                rva_r <= rv1_a;
                rvb_r <= rv1_b;
                if (rv1_a) douta_r <= d1_a;
                if (rv1_b) doutb_r <= d1_b;
            end
        end

        assign douta   = douta_r;
        assign doutb   = doutb_r;
        assign rvalida = rva_r;
        assign rvalidb = rvb_r;
    end else begin : g_noreg
        assign douta   = d1_a;
        assign doutb   = d1_b;
        assign rvalida = rv1_a;
        assign rvalidb = rv1_b;
    end

endmodule

// File: tb/tb_dpsram_param_pipe.sv
// Scoreboard bench for dpsram_param_pipe: directed vectors push expected read
// data into per-port queues, a monitor pops and compares on every rvalid.
module tb_dpsram_param_pipe;

    localparam int DW   = 64;
    localparam int AW   = 12;
    localparam int SW   = 32;
    localparam int NS   = DW / SW;
    localparam int OREG = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0, enb = 1'b0;
    logic [NS-1:0] wea = '0, web = '0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [DW-1:0] dina = '0, dinb = '0;
    logic [DW-1:0] douta, doutb;
    logic          rvalida, rvalidb, coll, busy;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] mon_ea, mon_eb;

    always #5 clk = ~clk;

    dpsram_param_pipe #(.DW(DW), .AW(AW), .SW(SW), .OREG(OREG)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .wea     (wea),
        .addra   (addra),
        .dina    (dina),
        .douta   (douta),
        .rvalida (rvalida),
        .enb     (enb),
        .web     (web),
        .addrb   (addrb),
        .dinb    (dinb),
        .doutb   (doutb),
        .rvalidb (rvalidb),
        .coll    (coll),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (rvalida) begin
            tests++;
            if (exp_a.size() == 0) begin
                fails++;
                $display("[TB] FAIL porta_unexpected_rvalid got douta=%h required no read", douta);
            end else begin
                mon_ea = exp_a.pop_front();
                if (douta !== mon_ea) begin
                    fails++;
                    $display("[TB] FAIL porta_read got %h required %h", douta, mon_ea);
                end
            end
        end
        if (rvalidb) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("[TB] FAIL portb_unexpected_rvalid got doutb=%h required no read", doutb);
            end else begin
                mon_eb = exp_b.pop_front();
                if (doutb !== mon_eb) begin
                    fails++;
                    $display("[TB] FAIL portb_read got %h required %h", doutb, mon_eb);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(
        input logic ea, input logic [NS-1:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
        input logic eb, input logic [NS-1:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
        input logic pa, input logic [DW-1:0] xa, input logic pb, input logic [DW-1:0] xb);
        @(negedge clk);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        if (pa) exp_a.push_back(xa);
        if (pb) exp_b.push_back(xb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 0, '0, 0, '0);
    endtask

`ifdef DPSRAM_INIT_CLEAR_EN
    task automatic waitReady(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 10000);
        checkOutput(name, DW'(n), DW'(2**AW + 1));
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_douta", douta, '0);
        checkOutput("reset_doutb", doutb, '0);
        checkOutput("reset_flags", DW'({rvalida, rvalidb, coll}), '0);
`ifdef DPSRAM_INIT_CLEAR_EN
        checkOutput("reset_busy", DW'(busy), DW'(1));
`else
        checkOutput("reset_busy", DW'(busy), DW'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DPSRAM_INIT_CLEAR_EN
        waitReady("busy_after_reset");
        applyStimulus(1, 2'b00, 12'h000, '0, 1, 2'b00, 12'hFFF, '0, 1, 64'h0, 1, 64'h0);
        applyStimulus(1, 2'b00, 12'h7A5, '0, 1, 2'b00, 12'h001, '0, 1, 64'h0, 1, 64'h0);
        idle(4);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        waitReady("busy_restart");
`endif

        // Full write then read on the other port
        applyStimulus(1, 2'b11, 12'h010, 64'h0123_4567_89AB_CDEF, 0, '0, '0, '0, 0, '0, 0, '0);
        applyStimulus(0, '0, '0, '0, 1, 2'b00, 12'h010, '0, 0, '0, 1, 64'h0123_4567_89AB_CDEF);

        // Partial write keeps the unselected upper slice
        applyStimulus(1, 2'b11, 12'h020, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, '0, '0, 0, '0, 0, '0);
        applyStimulus(1, 2'b01, 12'h020, 64'h0, 0, '0, '0, '0, 0, '0, 0, '0);
        applyStimulus(1, 2'b00, 12'h020, '0, 0, '0, '0, '0, 1, 64'hFFFF_FFFF_0000_0000, 0, '0);

        // Full-overlap collision: A wins, coll pulses once
        applyStimulus(1, 2'b11, 12'h100, 64'hAAAA_AAAA_AAAA_AAAA, 1, 2'b11, 12'h100, 64'h5555_5555_5555_5555, 0, '0, 0, '0);
        idle(1);
        checkOutput("coll_pulse", DW'(coll), DW'(1));
        idle(1);
        checkOutput("coll_single", DW'(coll), DW'(0));
        applyStimulus(1, 2'b00, 12'h100, '0, 0, '0, '0, '0, 1, 64'hAAAA_AAAA_AAAA_AAAA, 0, '0);

        // Disjoint slices at one address: both written, no collision
        applyStimulus(1, 2'b10, 12'h100, 64'hAAAA_AAAA_AAAA_AAAA, 1, 2'b01, 12'h100, 64'h5555_5555_5555_5555, 0, '0, 0, '0);
        idle(1);
        checkOutput("coll_disjoint", DW'(coll), DW'(0));
        applyStimulus(0, '0, '0, '0, 1, 2'b00, 12'h100, '0, 0, '0, 1, 64'hAAAA_AAAA_5555_5555);

        // Read-during-write forwarding, full and partial, both directions
        applyStimulus(1, 2'b11, 12'h200, 64'h1, 0, '0, '0, '0, 0, '0, 0, '0);
        applyStimulus(1, 2'b11, 12'h200, 64'h2, 1, 2'b00, 12'h200, '0, 0, '0, 1, 64'h2);
        applyStimulus(1, 2'b01, 12'h200, 64'hDEAD_BEEF_0000_0003, 1, 2'b00, 12'h200, '0, 0, '0, 1, 64'h3);
        applyStimulus(1, 2'b00, 12'h200, '0, 1, 2'b10, 12'h200, 64'h7777_7777_0000_0000, 1, 64'h7777_7777_0000_0003, 0, '0);

        // Read/read of one address
        applyStimulus(1, 2'b00, 12'h010, '0, 1, 2'b00, 12'h010, '0, 1, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF);

        // Back-to-back pipelined reads
        for (int i = 0; i < 16; i++)
            applyStimulus(1, 2'b11, AW'(i), DW'(i * 3), 0, '0, '0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 16; i++)
            applyStimulus(1, 2'b00, AW'(i), '0, 1, 2'b00, AW'(i), '0, 1, DW'(i * 3), 1, DW'(i * 3));
        idle(OREG + 3);

        // Writes leave dout holding the last read value
        applyStimulus(1, 2'b11, 12'h005, 64'h1234, 1, 2'b11, 12'h006, 64'h5678, 0, '0, 0, '0);
        idle(OREG + 2);
        checkOutput("hold_douta", douta, DW'(45));
        checkOutput("hold_doutb", doutb, DW'(45));

        // Reset with a read in flight: no rvalid may follow
        applyStimulus(1, 2'b00, 12'h010, '0, 1, 2'b00, 12'h010, '0, 0, '0, 0, '0);
        @(negedge clk);
        ena = 1'b0;
        enb = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_douta", douta, '0);
        checkOutput("midreset_rvalid", DW'({rvalida, rvalidb}), '0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DPSRAM_INIT_CLEAR_EN
        waitReady("busy_after_midreset");
        applyStimulus(1, 2'b00, 12'h100, '0, 0, '0, '0, '0, 1, 64'h0, 0, '0);
`else
        applyStimulus(1, 2'b00, 12'h100, '0, 0, '0, '0, '0, 1, 64'hAAAA_AAAA_5555_5555, 0, '0);
`endif
        idle(OREG + 4);

        checkOutput("drain_a", DW'(exp_a.size()), '0);
        checkOutput("drain_b", DW'(exp_b.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
